// File: rtl/ball_pkg.sv
// Shared types and defaults for the ball RAM capture controller.
package ball_pkg;

    typedef enum logic [1:0] {
        LIVE      = 2'd0,
        HOLD      = 2'd1,
        SNAP_WAIT = 2'd2,
        SNAP      = 2'd3
    } cap_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [11:0] MARKER_COLOUR = 12'h0F0;

endpackage

// File: rtl/ball_capture_ctrl_sync_edge_det.sv
// Registers the VGA-side sync strobes and derives frame/line boundary events.
module sync_edge_det (
    input  logic ball_clock,
    input  logic reset,
    input  logic h_sync,
    input  logic v_sync,
    output logic sof,
    output logic eof,
    output logic eol,
    output logic act
);

    logic h_sync_q;
    logic v_sync_q;
    logic armed;

    // armed blocks a false sof when reset releases in the middle of a frame
    always_ff @(posedge ball_clock or negedge reset) begin
        if (!reset) begin
            h_sync_q <= 1'b0;
            v_sync_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            h_sync_q <= h_sync;
            v_sync_q <= v_sync;
            if (!v_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign sof = v_sync & ~v_sync_q & armed;
    assign eof = ~v_sync & v_sync_q;
    assign eol = ~h_sync & h_sync_q & v_sync;
    assign act = h_sync & v_sync;

endmodule

// File: rtl/ball_capture_ctrl.sv
// Frame-store sequencer: pixel counters, RAM addressing and live/freeze/snapshot capture.
// State | meaning: LIVE write every frame; HOLD keep stored image; SNAP_WAIT HOLD with a snapshot pending; SNAP writing the snapshot frame.
module ball_capture_ctrl
    import ball_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int AW       = 20,
    parameter int FCW      = 16
) (
    input  logic           ball_clock,
    input  logic           reset,
    input  logic           h_sync,
    input  logic           v_sync,
    input  logic           freeze,
    input  logic           snap,
    input  logic [8:0]     horz_line_in,
    input  logic [9:0]     vert_line_in,
    output logic [9:0]     x_cnt,
    output logic [8:0]     y_cnt,
    output logic [AW-1:0]  wr_addr,
    output logic [AW-1:0]  rd_addr,
    output logic           wren,
    output logic           rden,
    output logic [8:0]     horz_line,
    output logic [9:0]     vert_line,
    output logic           marker_valid,
    output logic           frozen,
    output logic           snap_done,
    output logic [FCW-1:0] frame_cnt
);

    localparam logic [9:0]    X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]    Y_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [AW-1:0] PIX_LAST = AW'(H_ACTIVE * V_ACTIVE - 1);

    logic sof, eof, eol, act;

    cap_state_t state, state_nxt;
    logic       wr_frame, wr_frame_nxt;
    logic       done_nxt;

    logic [9:0]    x_pos;
    logic [AW-1:0] pix_idx;
    logic [AW-1:0] pix_base;

    sync_edge_det u_sync_edge_det (
        .ball_clock (ball_clock),
        .reset      (reset),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .sof        (sof),
        .eof        (eof),
        .eol        (eol),
        .act        (act)
    );

    always_ff @(posedge ball_clock or negedge reset) begin
        if (!reset) begin
            state     <= LIVE;
            wr_frame  <= 1'b0;
            snap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_frame  <= wr_frame_nxt;
            snap_done <= done_nxt;
        end
    end

    // wr_frame only changes at sof (or on leaving SNAP at eof), so a frame is never torn
    always_comb begin
        state_nxt    = state;
        wr_frame_nxt = wr_frame;
        done_nxt     = 1'b0;
        case (state)
            LIVE: begin
                if (sof) begin
                    if (freeze) begin
                        state_nxt    = HOLD;
                        wr_frame_nxt = 1'b0;
                    end else begin
                        wr_frame_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (sof) begin
                    if (!freeze) begin
                        state_nxt    = LIVE;
                        wr_frame_nxt = 1'b1;
                    end else if (snap) begin
                        state_nxt    = SNAP;
                        wr_frame_nxt = 1'b1;
                    end else begin
                        wr_frame_nxt = 1'b0;
                    end
                end else if (snap) begin
                    state_nxt = SNAP_WAIT;
                end
            end
            SNAP_WAIT: begin
                if (sof) begin
                    state_nxt    = freeze ? SNAP : LIVE;
                    wr_frame_nxt = 1'b1;
                end
            end
            SNAP: begin
                if (eof) begin
                    state_nxt    = HOLD;
                    wr_frame_nxt = 1'b0;
                    done_nxt     = 1'b1;
                end
            end
            default: begin
                state_nxt    = LIVE;
                wr_frame_nxt = 1'b0;
            end
        endcase
    end

    assign frozen   = (state == HOLD) || (state == SNAP_WAIT);
    assign pix_base = sof ? '0 : pix_idx;
    assign rd_addr  = wr_addr;

    // Outputs trail the sampled syncs by one cycle; the pixel data path carries the same delay.
    always_ff @(posedge ball_clock or negedge reset) begin
        if (!reset) begin
            x_cnt   <= '0;
            x_pos   <= '0;
            y_cnt   <= '0;
            wr_addr <= '0;
            pix_idx <= '0;
            rden    <= 1'b0;
            wren    <= 1'b0;
        end else begin
            rden <= act;
            wren <= act & wr_frame_nxt;

            if (act) begin
                x_cnt <= x_pos;
                x_pos <= (x_pos == X_LAST) ? X_LAST : x_pos + 10'd1;
            end else begin
                x_cnt <= '0;
                x_pos <= '0;
            end

            if (!v_sync) begin
                y_cnt <= '0;
            end else if (eol && (y_cnt != Y_LAST)) begin
                y_cnt <= y_cnt + 9'd1;
            end

            if (act) begin
                wr_addr <= pix_base;
                pix_idx <= (pix_base == PIX_LAST) ? PIX_LAST : pix_base + AW'(1);
            end else if (sof) begin
                wr_addr <= '0;
                pix_idx <= '0;
            end
        end
    end

    always_ff @(posedge ball_clock or negedge reset) begin
        if (!reset) begin
            horz_line    <= '0;
            vert_line    <= '0;
            marker_valid <= 1'b0;
            frame_cnt    <= '0;
        end else if (eof) begin
            frame_cnt <= frame_cnt + FCW'(1);
            if (wr_frame) begin
                horz_line    <= horz_line_in;
                vert_line    <= vert_line_in;
                marker_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ball_capture_ctrl.sv
// Directed bench for ball_capture_ctrl on an 8x4 frame.
module tb_ball_capture_ctrl;

    localparam int AW  = 20;
    localparam int FCW = 16;

    logic           ball_clock = 1'b0;
    logic           reset = 1'b0;
    logic           h_sync = 1'b0;
    logic           v_sync = 1'b0;
    logic           freeze = 1'b0;
    logic           snap = 1'b0;
    logic [8:0]     horz_line_in = '0;
    logic [9:0]     vert_line_in = '0;
    logic [9:0]     x_cnt;
    logic [8:0]     y_cnt;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic           wren;
    logic           rden;
    logic [8:0]     horz_line;
    logic [9:0]     vert_line;
    logic           marker_valid;
    logic           frozen;
    logic           snap_done;
    logic [FCW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    int wren_cnt, rden_cnt, addr_err, last_addr, x_max, y_max, done_cnt, frozen_sof;

    ball_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .AW(AW), .FCW(FCW)) dut (
        .ball_clock   (ball_clock),
        .reset        (reset),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .freeze       (freeze),
        .snap         (snap),
        .horz_line_in (horz_line_in),
        .vert_line_in (vert_line_in),
        .x_cnt        (x_cnt),
        .y_cnt        (y_cnt),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .wren         (wren),
        .rden         (rden),
        .horz_line    (horz_line),
        .vert_line    (vert_line),
        .marker_valid (marker_valid),
        .frozen       (frozen),
        .snap_done    (snap_done),
        .frame_cnt    (frame_cnt)
    );

    always #5 ball_clock = ~ball_clock;

    task automatic check_val(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act_v, exp_v);
        end
    endtask

    task automatic clear_stats();
        wren_cnt = 0; rden_cnt = 0; addr_err = 0; last_addr = 0;
        x_max = 0; y_max = 0; done_cnt = 0; frozen_sof = 0;
    endtask

    // drive, clock, then sample 1 time unit after the edge
    task automatic tick(input logic h, input logic v, input logic s, input int k);
        int exp_addr;
        h_sync = h; v_sync = v; snap = s;
        @(posedge ball_clock);
        #1;
        if (wren) begin
            exp_addr = (wren_cnt > 31) ? 31 : wren_cnt;
            if (int'(wr_addr) != exp_addr || rd_addr != wr_addr) addr_err++;
            wren_cnt++;
            last_addr = int'(wr_addr);
        end
        if (rden) rden_cnt++;
        if (int'(x_cnt) > x_max) x_max = int'(x_cnt);
        if (int'(y_cnt) > y_max) y_max = int'(y_cnt);
        if (snap_done) done_cnt++;
        if (k == 0) frozen_sof = int'(frozen);
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, (i == 0) ? s : 1'b0, -1);
    endtask

    task automatic run_frame(input int line_len, input int freeze_at, input int rst_at);
        int k;
        k = 0;
        clear_stats();
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < line_len + 3; p++) begin
                if (k == freeze_at) freeze = 1'b1;
                if (k == rst_at) begin
                    h_sync = (p < line_len); v_sync = 1'b1; reset = 1'b0;
                    #1;
                    check_val("rst_wren", wren, 0);
                    check_val("rst_rden", rden, 0);
                    check_val("rst_wr_addr", wr_addr, 0);
                    check_val("rst_x_cnt", x_cnt, 0);
                    check_val("rst_y_cnt", y_cnt, 0);
                    check_val("rst_frame_cnt", frame_cnt, 0);
                    check_val("rst_marker_valid", marker_valid, 0);
                    check_val("rst_horz_line", horz_line, 0);
                    @(posedge ball_clock);
                    #1;
                    reset = 1'b1;
                    clear_stats();
                end else begin
                    tick(p < line_len, 1'b1, 1'b0, k);
                end
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            tick(1'b0, 1'b0, 1'b0, -1);
            k++;
        end
    endtask

    initial begin
        #2;
        check_val("reset_wren", wren, 0);
        check_val("reset_frame_cnt", frame_cnt, 0);
        check_val("reset_frozen", frozen, 0);
        check_val("reset_snap_done", snap_done, 0);
        @(posedge ball_clock);
        #1;
        reset = 1'b1;
        idle(3, 1'b0);

        // two live frames
        horz_line_in = 9'd5; vert_line_in = 10'd9;
        run_frame(8, -1, -1);
        check_val("a_wren_cnt", wren_cnt, 32);
        check_val("a_rden_cnt", rden_cnt, 32);
        check_val("a_addr_seq", addr_err, 0);
        check_val("a_last_addr", last_addr, 31);
        check_val("a_x_max", x_max, 7);
        check_val("a_y_max", y_max, 3);
        check_val("a_frame_cnt", frame_cnt, 1);
        check_val("a_marker_valid", marker_valid, 1);
        check_val("a_horz_line", horz_line, 5);
        check_val("a_vert_line", vert_line, 9);
        run_frame(8, -1, -1);
        check_val("b_wren_cnt", wren_cnt, 32);
        check_val("b_frame_cnt", frame_cnt, 2);

        // freeze raised mid-frame: this frame completes, next one is held
        horz_line_in = 9'd7; vert_line_in = 10'd300;
        run_frame(8, 20, -1);
        check_val("c_wren_cnt", wren_cnt, 32);
        check_val("c_horz_line", horz_line, 7);
        check_val("c_vert_line", vert_line, 300);
        check_val("c_frozen_after", frozen, 0);
        horz_line_in = 9'd100; vert_line_in = 10'd1;
        run_frame(8, -1, -1);
        check_val("d_wren_cnt", wren_cnt, 0);
        check_val("d_frozen_at_sof", frozen_sof, 1);
        check_val("d_horz_line_kept", horz_line, 7);
        check_val("d_frame_cnt", frame_cnt, 4);

        // snapshot while frozen: exactly one frame written
        idle(2, 1'b1);
        check_val("snap_wait_frozen", frozen, 1);
        run_frame(8, -1, -1);
        check_val("e_wren_cnt", wren_cnt, 32);
        check_val("e_snap_done_cnt", done_cnt, 1);
        check_val("e_frozen_at_sof", frozen_sof, 0);
        check_val("e_horz_line", horz_line, 100);
        check_val("e_frozen_after", frozen, 1);
        horz_line_in = 9'd50;
        run_frame(8, -1, -1);
        check_val("f_wren_cnt", wren_cnt, 0);
        check_val("f_snap_done_cnt", done_cnt, 0);
        run_frame(8, -1, -1);
        check_val("g_wren_cnt", wren_cnt, 0);
        check_val("g_horz_line_kept", horz_line, 100);
        check_val("g_frame_cnt", frame_cnt, 7);

        // release freeze, then a snap in LIVE is ignored
        freeze = 1'b0;
        run_frame(8, -1, -1);
        check_val("h_wren_cnt", wren_cnt, 32);
        check_val("h_frozen_at_sof", frozen_sof, 0);
        idle(2, 1'b1);
        check_val("live_snap_frozen", frozen, 0);
        run_frame(8, -1, -1);
        check_val("i_wren_cnt", wren_cnt, 32);
        check_val("i_snap_done_cnt", done_cnt, 0);
        check_val("i_frame_cnt", frame_cnt, 9);

        // overlong lines saturate x and the address
        run_frame(10, -1, -1);
        check_val("j_wren_cnt", wren_cnt, 40);
        check_val("j_x_max", x_max, 7);
        check_val("j_addr_seq", addr_err, 0);
        check_val("j_last_addr", last_addr, 31);
        check_val("j_frame_cnt", frame_cnt, 10);

        // reset at pixel 13 of a live frame
        run_frame(8, -1, 16);
        check_val("k_wren_after_rst", wren_cnt, 0);
        check_val("k_frame_cnt", frame_cnt, 1);
        check_val("k_marker_valid", marker_valid, 0);
        run_frame(8, -1, -1);
        check_val("l_wren_cnt", wren_cnt, 32);
        check_val("l_addr_seq", addr_err, 0);
        check_val("l_frame_cnt", frame_cnt, 2);
        check_val("l_marker_valid", marker_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_capture_ctrl.md
Name: ball_capture_ctrl

Overview:
- Sequences the 1-bit red-detection frame store (ball RAM).
- Generates pixel x/y counters, write/read addresses and enables from the VGA-side h_sync/v_sync active-high strobes.
- Implements live, frozen and single-snapshot capture modes, switching only on frame boundaries so the stored image never tears.
- Latches the red-object centre lines once per written frame, so the overlay marker always matches the stored image.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- AW, 20, RAM address width. Must satisfy 2^AW >= H_ACTIVE*V_ACTIVE.
- FCW, 16, frame counter width.

Ports:
- ball_clock  in  1  pixel clock; all logic rises on it.
- reset  in  1  asynchronous, active-low reset.
- h_sync  in  1  high during the active part of a line.
- v_sync  in  1  high during the active lines of a frame.
- freeze  in  1  level; request to hold the stored image.
- snap  in  1  single-cycle pulse; capture exactly one new frame while frozen.
- horz_line_in  in  9  row of the object centre from the red filter.
- vert_line_in  in  10  column of the object centre from the red filter.
- x_cnt  out  10  column of the current active pixel.
- y_cnt  out  9  row of the current active pixel.
- wr_addr  out  AW  ball RAM write address.
- rd_addr  out  AW  ball RAM read address (equals wr_addr).
- wren  out  1  ball RAM write enable.
- rden  out  1  ball RAM read enable.
- horz_line  out  9  latched marker row.
- vert_line  out  10  latched marker column.
- marker_valid  out  1  high once any frame has been written.
- frozen  out  1  high in HOLD or SNAP_WAIT.
- snap_done  out  1  one-cycle pulse when a snapshot frame completes.
- frame_cnt  out  FCW  count of completed frames.

Behaviour:
- Reset: every output is 0, the state is LIVE and snap_pend is 0.
- Edge detection: registered h_sync_q and v_sync_q.
  - sof = v_sync & ~v_sync_q; eof = ~v_sync & v_sync_q.
  - eol = ~h_sync & h_sync_q, qualified by v_sync.
  - act = h_sync & v_sync.
- Output latency: x_cnt, y_cnt, wr_addr, rd_addr, wren and rden are registered, one cycle after the sampled h_sync/v_sync. The pixel data path must be delayed by one cycle to match.
- x_cnt: increments on each act cycle and clears when h_sync is low. Saturates at H_ACTIVE-1 and never wraps inside a line.
- y_cnt: increments on eol and clears when v_sync is low. Saturates at V_ACTIVE-1.
- wr_addr: running pixel index. Clears on sof, increments after each act cycle, saturates at H_ACTIVE*V_ACTIVE-1. rd_addr equals wr_addr.
- rden = act, registered.
- wren = act & wr_frame, registered. wr_frame is decided only at sof and held constant for the whole frame.
- State machine (transitions only on the listed events):
  - LIVE: at sof, if freeze then go to HOLD with wr_frame=0; otherwise stay in LIVE with wr_frame=1.
  - HOLD:
    - At sof, if ~freeze then go to LIVE with wr_frame=1.
    - Else if snap_pend then go to SNAP with wr_frame=1 and clear snap_pend.
    - Otherwise wr_frame=0.
  - SNAP_WAIT: alias of HOLD with snap_pend=1. It exists only for the frozen output and debug.
  - SNAP: at eof go to HOLD, pulse snap_done for one cycle and clear wr_frame.
- snap_pend: set by snap in HOLD. snap in LIVE or SNAP is ignored. snap coinciding with sof in HOLD is taken immediately and goes straight to SNAP.
- Freeze inside SNAP: deasserting freeze during SNAP has no effect until the following sof in HOLD, which then returns to LIVE.
- Marker latch: at eof, if wr_frame=1, then horz_line <= horz_line_in, vert_line <= vert_line_in and marker_valid <= 1. Frames that are not written leave the marker unchanged.
- frame_cnt: increments on every eof, written or not, and wraps modulo 2^FCW.
- v_sync low mid-line: x_cnt and y_cnt clear. eof is taken as normal, even if the frame is short.
- Reset mid-frame: everything returns to LIVE with wr_frame=0. No writes occur until the next sof.

Decomposition:
- Shared package ball_pkg:
  - State enum: LIVE, HOLD, SNAP_WAIT, SNAP.
  - H_ACTIVE and V_ACTIVE defaults.
  - Marker colour constant.
- One sub-module, sync_edge_det: registers h_sync/v_sync and outputs sof, eof, eol and act.
- The counters and FSM stay in ball_capture_ctrl.

Test Plan:
- Bench parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=4.
- Reset then 2 frames, freeze=0 -> wren high for exactly 32 cycles per frame; wr_addr runs 0..31; frame_cnt=2; marker_valid=1 after the first eof.
- freeze raised mid-frame 1 -> frame 1 writes all 32 pixels; frame 2 has wren=0 throughout; frozen=1 from the frame-2 sof; the marker keeps its frame-1 value.
- In HOLD, snap pulse, then 3 frames -> only the next frame is written (32 wren cycles); snap_done pulses once at its eof; later frames are not written.
- Snap pulse in LIVE -> ignored: snap_pend stays 0 and no snap_done occurs.
- Overlong line (h_sync high for 10 cycles) -> x_cnt saturates at 7; wr_addr stops at 31 by the end of the frame.
- Reset asserted at pixel 13 of a LIVE frame -> all outputs 0 immediately; no wren until the next sof; writing then resumes.
